// File: rtl/counter_pkg.sv
//------------------------------------------------------------------------------
// Module     : counter_pkg
// Description: Shared encodings for the counter_ctrl command sequencer.
//              Holds the command opcode enum, the controller state enum and
//              the matching 2-bit state constants used by the FSM and bench.
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package counter_pkg;

  localparam int unsigned OP_W    = 3;
  localparam int unsigned STATE_W = 2;

  // Command opcodes carried on cmd_op.
  typedef enum logic [OP_W-1:0] {
    OP_NOP        = 3'd0,
    OP_LOAD       = 3'd1,
    OP_SET_LIMIT  = 3'd2,
    OP_START_UP   = 3'd3,
    OP_START_DOWN = 3'd4,
    OP_PAUSE      = 3'd5,
    OP_RESUME     = 3'd6,
    OP_STOP       = 3'd7
  } cmd_op_t;

  // Controller state as seen on the state output.
  typedef enum logic [STATE_W-1:0] {
    CS_IDLE  = 2'd0,
    CS_RUN   = 2'd1,
    CS_PAUSE = 2'd2,
    CS_DONE  = 2'd3
  } ctrl_state_t;

  // Plain constants for the FSM register, kept bit-identical to ctrl_state_t
  // so older code that compares raw 2-bit values keeps working.
  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_RUN   = 2'd1;
  localparam logic [STATE_W-1:0] ST_PAUSE = 2'd2;
  localparam logic [STATE_W-1:0] ST_DONE  = 2'd3;

  // True for either START opcode.
  function automatic logic is_start(input logic [OP_W-1:0] op);
    return (op == OP_START_UP) || (op == OP_START_DOWN);
  endfunction

endpackage : counter_pkg

`default_nettype wire

// File: rtl/counter_ctrl_tick_gen.sv
//------------------------------------------------------------------------------
// Module     : tick_gen
// Description: Prescaler producing one enable strobe every TICK_DIV enabled
//              clk cycles. The prescaler counts 0..TICK_DIV-1 while en is
//              high, holds its value while en is low, and is cleared by clr.
// Ports      : clk    - system clock
//              rst    - synchronous active-high reset
//              en     - advance the prescaler this cycle
//              clr    - force the prescaler back to 0 (wins over en)
//              expire - combinational: prescaler wraps on this edge
//              tick   - registered one-cycle strobe, follows expire
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tick_gen #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expire,
  output logic tick
);

  localparam int unsigned     PW     = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   C_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;
  logic          tick_q;
  logic          w_at_last;

  assign w_at_last = (presc_q == C_LAST);

  // expire is exported unregistered so the owner can update its count on
  // the same edge that raises tick; that keeps tick aligned with count.
  assign expire = en && !clr && w_at_last;

  always_comb begin
    presc_d = presc_q;
    if (clr) begin
      presc_d = '0;
    end else if (en) begin
      presc_d = w_at_last ? '0 : presc_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= expire;
    end
  end

  assign tick = tick_q;

endmodule : tick_gen

`default_nettype wire

// File: rtl/counter_ctrl.sv
//------------------------------------------------------------------------------
// Module     : counter_ctrl
// Description: Command-driven sequencer for an event counter paced by an
//              internal tick prescaler. Commands arrive over a valid/ready
//              port; terminal count is flagged with a one-cycle done pulse.
// Ports      : clk        - system clock
//              rst        - synchronous active-high reset
//              cmd_valid  - command present
//              cmd_ready  - command can be accepted this cycle (registered)
//              cmd_op     - opcode, see counter_pkg::cmd_op_t
//              cmd_data   - operand for LOAD / SET_LIMIT
//              count      - current count
//              state      - IDLE=0, RUN=1, PAUSE=2, DONE=3
//              tick       - one-cycle strobe on prescaler expiry in RUN
//              done       - one-cycle pulse on reaching the terminal value
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module counter_ctrl #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] count,
  output logic [1:0]       state,
  output logic             tick,
  output logic             done
);

  import counter_pkg::*;

  // Registered state
  logic [WIDTH-1:0]   count_q,     count_d;
  logic [WIDTH-1:0]   limit_q,     limit_d;
  logic               dir_down_q,  dir_down_d;
  logic [STATE_W-1:0] state_q,     state_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               done_q,      done_d;

  // Combinational helpers
  cmd_op_t          w_op;
  logic             w_accept;
  logic             w_idle_or_done;
  logic             w_start_ok;
  logic             w_run_en;
  logic             w_expire;
  logic             w_tick;
  logic [WIDTH-1:0] w_term_run;
  logic [WIDTH-1:0] w_term_start;

  assign w_op           = cmd_op_t'(cmd_op);
  assign w_accept       = cmd_valid && cmd_ready_q;
  assign w_idle_or_done = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign w_start_ok     = w_accept && is_start(cmd_op) && w_idle_or_done;

  // Any accepted command freezes the prescaler for that cycle, so a command
  // landing on an expiry cycle swallows the tick rather than racing it.
  assign w_run_en = (state_q == ST_RUN) && !w_accept;

  // Terminal value for the current direction, and for the direction a START
  // is about to select (needed for the immediate-terminal START case).
  assign w_term_run   = dir_down_q ? '0 : limit_q;
  assign w_term_start = (w_op == OP_START_DOWN) ? '0 : limit_q;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .en     (w_run_en),
    .clr    (w_start_ok),
    .expire (w_expire),
    .tick   (w_tick)
  );

  always_comb begin
    count_d     = count_q;
    limit_d     = limit_q;
    dir_down_d  = dir_down_q;
    state_d     = state_q;
    done_d      = 1'b0;
    // Ready drops for exactly the cycle following an acceptance.
    cmd_ready_d = !w_accept;

    if (w_accept) begin
      case (w_op)
        OP_LOAD: begin
          count_d = cmd_data;
          state_d = ST_IDLE;
        end
        OP_SET_LIMIT: begin
          limit_d = cmd_data;
        end
        OP_START_UP, OP_START_DOWN: begin
          if (w_idle_or_done) begin
            dir_down_d = (w_op == OP_START_DOWN);
            // Already sitting on the terminal value: finish without a tick.
            if (count_q == w_term_start) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_RUN;
            end
          end
        end
        OP_PAUSE: begin
          if (state_q == ST_RUN) begin
            state_d = ST_PAUSE;
          end
        end
        OP_RESUME: begin
          if (state_q == ST_PAUSE) begin
            state_d = ST_RUN;
          end
        end
        OP_STOP: begin
          state_d = ST_IDLE;
        end
        default: begin
          // NOP: nothing to do
        end
      endcase
    end else if (w_expire) begin
      // Up-count wraps modulo 2^WIDTH so a count above limit rolls through
      // zero before reaching it; down-count always stops at zero.
      count_d = dir_down_q ? (count_q - 1'b1) : (count_q + 1'b1);
      if (count_d == w_term_run) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      limit_q     <= '1;
      dir_down_q  <= 1'b0;
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      count_q     <= count_d;
      limit_q     <= limit_d;
      dir_down_q  <= dir_down_d;
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      done_q      <= done_d;
    end
  end

  assign count     = count_q;
  assign state     = state_q;
  assign cmd_ready = cmd_ready_q;
  assign tick      = w_tick;
  assign done      = done_q;

endmodule : counter_ctrl

`default_nettype wire

// File: tb/tb_counter_ctrl.sv
//------------------------------------------------------------------------------
// Module     : tb_counter_ctrl
// Description: Self-checking bench for counter_ctrl (WIDTH=8, TICK_DIV=4).
//              A table of per-cycle vectors covers the basic up/down/wrap
//              runs; hand-written sequences cover pause/resume, STOP on an
//              expiry cycle, immediate-terminal START and reset in RUN.
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_counter_ctrl;

  import counter_pkg::*;

  localparam int unsigned WIDTH    = 8;
  localparam int unsigned TICK_DIV = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [WIDTH-1:0] count;
  logic [1:0]       state;
  logic             tick;
  logic             done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  counter_ctrl #(
    .WIDTH    (WIDTH),
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .count     (count),
    .state     (state),
    .tick      (tick),
    .done      (done)
  );

  // One record = one command (or idle) followed by reps cycles that all
  // expect the same outputs; the command is only driven on the first cycle.
  typedef struct {
    logic       valid;
    logic [2:0] op;
    logic [7:0] data;
    int         reps;
    logic [7:0] e_count;
    logic [1:0] e_state;
    logic       e_tick;
    logic       e_done;
    logic       e_ready;
  } vec_t;

  vec_t vecs[$];

  task automatic addv(input logic valid, input logic [2:0] op, input logic [7:0] data,
                      input int reps, input logic [7:0] e_count, input logic [1:0] e_state,
                      input logic e_tick, input logic e_done, input logic e_ready);
    vec_t v;
    v.valid = valid; v.op = op; v.data = data; v.reps = reps;
    v.e_count = e_count; v.e_state = e_state;
    v.e_tick = e_tick; v.e_done = e_done; v.e_ready = e_ready;
    vecs.push_back(v);
  endtask

  // Idle row shorthand
  task automatic addi(input int reps, input logic [7:0] e_count, input logic [1:0] e_state,
                      input logic e_tick, input logic e_done);
    addv(1'b0, OP_NOP, 8'h00, reps, e_count, e_state, e_tick, e_done, 1'b1);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] e_count, input logic [1:0] e_state,
                         input logic e_tick, input logic e_done, input logic e_ready);
    chk({tag, ".count"}, int'(count), int'(e_count));
    chk({tag, ".state"}, int'(state), int'(e_state));
    chk({tag, ".tick"},  int'(tick),  int'(e_tick));
    chk({tag, ".done"},  int'(done),  int'(e_done));
    chk({tag, ".ready"}, int'(cmd_ready), int'(e_ready));
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a command for one edge; it must be accepted and drop ready.
  task automatic send(input logic [2:0] op, input logic [7:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    step();
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
    cmd_data  = 8'h00;
    chk("ready_drop", int'(cmd_ready), 0);
  endtask

  // Setup command: send, then one idle cycle in which ready must return.
  task automatic cmd(input logic [2:0] op, input logic [7:0] data);
    send(op, data);
    step();
    chk("ready_back", int'(cmd_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d of %0d checks",
             n_errors, n_checks);
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
    cmd_data  = 8'h00;

    // ---- Vector table ----------------------------------------------------
    // Up-count to limit 3
    addv(1'b1, OP_SET_LIMIT, 8'd3, 1, 8'd0, ST_IDLE, 1'b0, 1'b0, 1'b0);
    addi(1, 8'd0, ST_IDLE, 1'b0, 1'b0);
    addv(1'b1, OP_START_UP, 8'd0, 1, 8'd0, ST_RUN, 1'b0, 1'b0, 1'b0);
    addi(3, 8'd0, ST_RUN, 1'b0, 1'b0);
    addi(1, 8'd1, ST_RUN, 1'b1, 1'b0);
    addi(3, 8'd1, ST_RUN, 1'b0, 1'b0);
    addi(1, 8'd2, ST_RUN, 1'b1, 1'b0);
    addi(3, 8'd2, ST_RUN, 1'b0, 1'b0);
    addi(1, 8'd3, ST_DONE, 1'b1, 1'b1);
    addi(6, 8'd3, ST_DONE, 1'b0, 1'b0);
    // LOAD 5, count down to 0
    addv(1'b1, OP_LOAD, 8'd5, 1, 8'd5, ST_IDLE, 1'b0, 1'b0, 1'b0);
    addi(1, 8'd5, ST_IDLE, 1'b0, 1'b0);
    addv(1'b1, OP_START_DOWN, 8'd0, 1, 8'd5, ST_RUN, 1'b0, 1'b0, 1'b0);
    addi(3, 8'd5, ST_RUN, 1'b0, 1'b0);
    for (int v = 4; v >= 1; v--) begin
      addi(1, 8'(v), ST_RUN, 1'b1, 1'b0);
      addi(3, 8'(v), ST_RUN, 1'b0, 1'b0);
    end
    addi(1, 8'd0, ST_DONE, 1'b1, 1'b1);
    addi(5, 8'd0, ST_DONE, 1'b0, 1'b0);
    // Wrap-around: LOAD FE, limit 1
    addv(1'b1, OP_LOAD, 8'hFE, 1, 8'hFE, ST_IDLE, 1'b0, 1'b0, 1'b0);
    addi(1, 8'hFE, ST_IDLE, 1'b0, 1'b0);
    addv(1'b1, OP_SET_LIMIT, 8'd1, 1, 8'hFE, ST_IDLE, 1'b0, 1'b0, 1'b0);
    addi(1, 8'hFE, ST_IDLE, 1'b0, 1'b0);
    addv(1'b1, OP_START_UP, 8'd0, 1, 8'hFE, ST_RUN, 1'b0, 1'b0, 1'b0);
    addi(3, 8'hFE, ST_RUN, 1'b0, 1'b0);
    addi(1, 8'hFF, ST_RUN, 1'b1, 1'b0);
    addi(3, 8'hFF, ST_RUN, 1'b0, 1'b0);
    addi(1, 8'h00, ST_RUN, 1'b1, 1'b0);
    addi(3, 8'h00, ST_RUN, 1'b0, 1'b0);
    addi(1, 8'h01, ST_DONE, 1'b1, 1'b1);
    addi(3, 8'h01, ST_DONE, 1'b0, 1'b0);

    // ---- Reset -----------------------------------------------------------
    repeat (3) step();
    chk_all("reset", 8'd0, ST_IDLE, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;

    // ---- Apply table -----------------------------------------------------
    foreach (vecs[i]) begin
      for (int r = 0; r < vecs[i].reps; r++) begin
        cmd_valid = vecs[i].valid && (r == 0);
        cmd_op    = vecs[i].op;
        cmd_data  = vecs[i].data;
        step();
        cmd_valid = 1'b0;
        chk_all($sformatf("vec%0d.%0d", i, r), vecs[i].e_count, vecs[i].e_state,
                vecs[i].e_tick, vecs[i].e_done, vecs[i].e_ready);
      end
    end
    cmd_op   = OP_NOP;
    cmd_data = 8'h00;

    // ---- Pause / resume --------------------------------------------------
    cmd(OP_SET_LIMIT, 8'd20);
    cmd(OP_LOAD, 8'd0);
    send(OP_START_UP, 8'd0);
    chk("pr_start.state", int'(state), int'(ST_RUN));
    for (int k = 0; k < 3; k++) begin
      step();
      chk("pr_pre.tick", int'(tick), 0);
    end
    step();
    chk("pr_tick1.tick", int'(tick), 1);
    chk("pr_tick1.count", int'(count), 1);
    step();
    step();
    send(OP_PAUSE, 8'd0);
    chk("pr_pause.state", int'(state), int'(ST_PAUSE));
    for (int k = 0; k < 10; k++) begin
      step();
      chk("pr_hold.count", int'(count), 1);
      chk("pr_hold.tick", int'(tick), 0);
      chk("pr_hold.state", int'(state), int'(ST_PAUSE));
    end
    send(OP_RESUME, 8'd0);
    chk("pr_resume.state", int'(state), int'(ST_RUN));
    step();
    chk("pr_res1.tick", int'(tick), 0);
    step();
    chk("pr_res2.tick", int'(tick), 1);
    chk("pr_res2.count", int'(count), 2);

    // ---- STOP on the prescaler expiry cycle -------------------------------
    step();
    step();
    step();
    chk("stop_pre.tick", int'(tick), 0);
    send(OP_STOP, 8'd0);
    chk("stop.tick", int'(tick), 0);
    chk("stop.count", int'(count), 2);
    chk("stop.state", int'(state), int'(ST_IDLE));
    step();
    chk_all("stop_after", 8'd2, ST_IDLE, 1'b0, 1'b0, 1'b1);

    // ---- Immediate terminal START ----------------------------------------
    cmd(OP_LOAD, 8'd7);
    cmd(OP_SET_LIMIT, 8'd7);
    send(OP_START_UP, 8'd0);
    chk_all("imm_up", 8'd7, ST_DONE, 1'b0, 1'b1, 1'b0);
    step();
    chk_all("imm_up_after", 8'd7, ST_DONE, 1'b0, 1'b0, 1'b1);
    cmd(OP_LOAD, 8'd0);
    send(OP_START_DOWN, 8'd0);
    chk_all("imm_dn", 8'd0, ST_DONE, 1'b0, 1'b1, 1'b0);

    // ---- Reset in RUN on the cycle a done would be raised -----------------
    step();
    cmd(OP_SET_LIMIT, 8'd1);
    cmd(OP_LOAD, 8'd0);
    send(OP_START_UP, 8'd0);
    step();
    step();
    step();
    chk("rr_pre.state", int'(state), int'(ST_RUN));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_all("rr_reset", 8'd0, ST_IDLE, 1'b0, 1'b0, 1'b1);
    step();
    chk_all("rr_after", 8'd0, ST_IDLE, 1'b0, 1'b0, 1'b1);
    // Limit must be back to all ones: FE counts up and finishes at FF.
    cmd(OP_LOAD, 8'hFE);
    send(OP_START_UP, 8'd0);
    step();
    step();
    step();
    chk("rr_lim_pre.count", int'(count), 8'hFE);
    step();
    chk_all("rr_lim_done", 8'hFF, ST_DONE, 1'b1, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_counter_ctrl

`default_nettype wire

// File: doc/counter_ctrl.md
# counter_ctrl

Command-driven sequencer for an 8-bit event counter paced by an internal tick prescaler. It runs entirely in the `clk` domain: the tick is a one-cycle enable strobe, never a derived clock. It accepts commands from a host or FSM over a valid/ready port (load, set limit, start up/down, pause, resume, stop) and signals terminal count with a one-cycle `done` pulse. It sits between board-level control logic and the LED/seven-segment display path.

## Interface
- `WIDTH`, default 8: counter and limit width.
- `TICK_DIV`, default 50_000_000: clk cycles per tick, must be ≥ 2. Prescaler width is `$clog2(TICK_DIV)`.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command can be accepted this cycle.
- `cmd_op`  in  3  opcode, encodings in `counter_pkg`.
- `cmd_data`  in  WIDTH  operand for LOAD and SET_LIMIT.
- `count`  out  WIDTH  current count.
- `state`  out  2  FSM state: IDLE=0, RUN=1, PAUSE=2, DONE=3.
- `tick`  out  1  one-cycle strobe when the prescaler expires in RUN.
- `done`  out  1  one-cycle pulse when the terminal count is reached.

## Operation
- Reset values:
  - `count`=0, `limit`=all ones, direction=up, prescaler=0.
  - `state`=IDLE, `cmd_ready`=1, `tick`=0, `done`=0.
- Handshake:
  - A command is accepted when `cmd_valid && cmd_ready`.
  - `cmd_ready` is registered and drops to 0 for exactly the one cycle after an acceptance, then returns to 1.
  - Maximum throughput is one command every 2 cycles. Ops that are illegal in the current state are accepted and ignored.
- Opcodes:
  - NOP=0.
  - LOAD=1: count←data, state→IDLE from any state.
  - SET_LIMIT=2: limit←data, state unchanged.
  - START_UP=3 / START_DOWN=4: legal in IDLE and DONE. Sets direction, clears the prescaler, state→RUN.
  - PAUSE=5: RUN→PAUSE; the prescaler value is held.
  - RESUME=6: PAUSE→RUN; the prescaler continues from its held value.
  - STOP=7: any state→IDLE, count held.
- Terminal value is `limit` when counting up and 0 when counting down.
- In RUN the prescaler counts 0..TICK_DIV-1. On reaching TICK_DIV-1 it wraps to 0 and `tick` pulses.
- On a tick, count←count±1 modulo 2^WIDTH. If the new value equals the terminal value: state→DONE and `done`=1 in the same cycle that `count` shows the terminal value.
- Wrap-around: counting up with count > limit passes 2^WIDTH−1→0 and continues to limit. Counting down never wraps, because it always stops at 0.
- START when count already equals the terminal value: state→DONE with a `done` pulse on the next cycle, with no tick.
- In DONE, count is held until LOAD, START or STOP.

## Timing
- Effects of a command (count, state, limit) are visible on the cycle after acceptance.
- The first tick after START occurs TICK_DIV cycles after the acceptance edge.
- A command accepted in the same cycle as a prescaler expiry has priority. That tick is suppressed: no `tick`, no count change.
  - LOAD/STOP/PAUSE therefore cannot race a count update.
- `tick` and `done` are registered and never high for more than 1 cycle. `done` is asserted only together with a tick or the immediate-terminal START case.
- Reset mid-RUN: next cycle shows all reset values, and any pending `done` is cancelled.

## Structure
- `counter_pkg` holds:
  - the `cmd_op_t` opcode enum;
  - the `ctrl_state_t` enum (IDLE/RUN/PAUSE/DONE);
  - the encodings used by the bench.
- Sub-module `tick_gen` (parameter `TICK_DIV`):
  - inputs `en` (RUN and no accepted command) and `clr` (START);
  - output `tick`.
- `counter_ctrl` holds the FSM, the count/limit registers and the handshake.

## Test plan
Benches use TICK_DIV=4, WIDTH=8.
- Reset, then START_UP with limit=3 → ticks every 4 cycles, count goes 1, 2, 3. `done` pulses once with count=3, state=DONE; no further ticks.
- LOAD 5, START_DOWN → count goes 4, 3, 2, 1, 0. `done` pulses with count=0, state=DONE, count held at 0.
- LOAD 0xFE, limit=1, START_UP → count goes 0xFF, 0x00, 0x01, then `done`.
- PAUSE 2 cycles after a tick, hold 10 cycles, RESUME → no count change while paused; the next tick comes exactly 2 cycles after resume acceptance.
- STOP accepted on the prescaler-expiry cycle → no `tick`, count unchanged, state=IDLE. `cmd_ready` is 0 for exactly 1 cycle after each acceptance.
- LOAD 7, limit=7, START_UP → DONE with a `done` pulse 1 cycle after acceptance and no tick. `rst` asserted in RUN → all outputs return to reset values the next cycle.
